lif_neuron_multisyn: RTL

Parametrised leaky integrate-and-fire neuron with N_SYN weighted synaptic inputs. It replaces the fixed single-input, +1-per-spike neuron core.
- Per-synapse signed weights are programmable at run time through a write port.
- The membrane potential is signed and saturating, with symmetric leak toward zero.
- Reset after firing is selectable: to zero, or subtract-threshold.
- An enable input freezes the neuron; a saturating spike counter is provided for observation.

It sits in the neuron array between the spike router and the output spike encoder.

---
 rtl/lif_neuron_multisyn.sv | 163 ++++++++++++++++
 1 files changed

// File: rtl/lif_neuron_multisyn.sv
// lif_neuron_multisyn: leaky integrate-and-fire neuron with N_SYN weighted
// synaptic inputs. The membrane potential is signed and saturating, leaks
// symmetrically toward zero, and is reset on fire either to zero or by
// subtracting the threshold. The neuron also has run-time programmable
// weights, a refractory period and a saturating fire counter.
module lif_neuron_multisyn #(
  parameter int N_SYN       = 8,
  parameter int W_W         = 8,
  parameter int V_W         = 16,
  parameter int THRESHOLD   = 100,
  parameter int LEAK        = 1,
  parameter int REFRACTORY  = 10,
  parameter int REF_W       = 8,
  parameter int RESET_MODE  = 0,
  parameter int WEIGHT_INIT = 1,
  localparam int A_W        = (N_SYN > 1) ? $clog2(N_SYN) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [N_SYN-1:0] spike_in,
  input  logic             wr_en,
  input  logic [A_W-1:0]   wr_addr,
  input  logic [W_W-1:0]   wr_data,
  input  logic             count_clr,
  output logic             spike_out,
  output logic [V_W-1:0]   v_mem,
  output logic             in_refractory,
  output logic [15:0]      spike_count
);

  // Internal arithmetic width. It is wide enough that summing every weight
  // onto the membrane potential can never overflow before saturation.
  localparam int S_W = V_W + W_W + $clog2(N_SYN) + 1;

  localparam logic signed [S_W-1:0] V_MAX  = {{(S_W-V_W+1){1'b0}}, {(V_W-1){1'b1}}};
  localparam logic signed [S_W-1:0] V_MIN  = {{(S_W-V_W+1){1'b1}}, {(V_W-1){1'b0}}};
  localparam logic signed [S_W-1:0] ZERO_S = {S_W{1'b0}};
  localparam logic signed [S_W-1:0] THR_S  = S_W'(THRESHOLD);
  localparam logic signed [S_W-1:0] LEAK_S = S_W'(LEAK);
  localparam logic [REF_W-1:0]      REF_INIT = REF_W'(REFRACTORY);
  localparam logic [REF_W-1:0]      REF_ONE  = REF_W'(1);
  localparam logic [REF_W-1:0]      REF_ZERO = REF_W'(0);

  logic signed [W_W-1:0] weight [N_SYN];
  logic [REF_W-1:0]      ref_cnt;

  logic signed [S_W-1:0] syn_sum;
  logic signed [S_W-1:0] v_ext;
  logic signed [S_W-1:0] v_l;
  logic signed [S_W-1:0] v_sum;
  logic signed [S_W-1:0] v_next_ext;
  logic [V_W-1:0]        v_next;
  logic [V_W-1:0]        v_fire;
  logic                  fire;

  // Clamp a wide signed value into the membrane potential range.
  function automatic logic [V_W-1:0] sat_v(input logic signed [S_W-1:0] x);
    logic [V_W-1:0] r;
    if (x > V_MAX) begin
      r = V_MAX[V_W-1:0];
    end else if (x < V_MIN) begin
      r = V_MIN[V_W-1:0];
    end else begin
      r = x[V_W-1:0];
    end
    return r;
  endfunction

  // Sum the weights of every synapse that spiked this cycle.
  always_comb begin
    syn_sum = ZERO_S;
    for (int i = 0; i < N_SYN; i++) begin
      if (spike_in[i]) begin
        syn_sum = syn_sum + {{(S_W-W_W){weight[i][W_W-1]}}, weight[i]};
      end else begin
        syn_sum = syn_sum;
      end
    end
  end

  // Leak toward zero on cycles without input, then add synaptic drive and
  // saturate. The fire decision and the reset value both come from here.
  always_comb begin
    v_ext = {{(S_W-V_W){v_mem[V_W-1]}}, v_mem};
    v_l   = v_ext;
    if (spike_in == '0) begin
      if (v_ext > ZERO_S) begin
        v_l = (v_ext > LEAK_S) ? (v_ext - LEAK_S) : ZERO_S;
      end else if (v_ext < ZERO_S) begin
        v_l = (v_ext < -LEAK_S) ? (v_ext + LEAK_S) : ZERO_S;
      end else begin
        v_l = ZERO_S;
      end
    end else begin
      v_l = v_ext;
    end
    v_sum      = v_l + syn_sum;
    v_next     = sat_v(v_sum);
    v_next_ext = {{(S_W-V_W){v_next[V_W-1]}}, v_next};
    fire       = en && (ref_cnt == REF_ZERO) && (v_next_ext >= THR_S);
    if (RESET_MODE == 1) begin
      v_fire = sat_v(v_next_ext - THR_S);
    end else begin
      v_fire = {V_W{1'b0}};
    end
  end

  assign in_refractory = (ref_cnt != REF_ZERO);

  // Membrane potential, refractory counter and the one-cycle fire pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v_mem     <= {V_W{1'b0}};
      ref_cnt   <= REF_ZERO;
      spike_out <= 1'b0;
    end else if (en) begin
      if (ref_cnt != REF_ZERO) begin
        ref_cnt   <= ref_cnt - REF_ONE;
        spike_out <= 1'b0;
      end else if (fire) begin
        v_mem     <= v_fire;
        ref_cnt   <= REF_INIT;
        spike_out <= 1'b1;
      end else begin
        v_mem     <= v_next;
        spike_out <= 1'b0;
      end
    end else begin
      spike_out <= 1'b0;
    end
  end

  // Saturating fire counter. A clear wins over a same-edge increment.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      spike_count <= 16'd0;
    end else if (count_clr) begin
      spike_count <= 16'd0;
    end else if (fire && (spike_count != 16'hFFFF)) begin
      spike_count <= spike_count + 16'd1;
    end else begin
      spike_count <= spike_count;
    end
  end

  // Weight table. Out-of-range addresses are dropped, and an integration on
  // the same edge still sees the previous weight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < N_SYN; i++) begin
        weight[i] <= W_W'(WEIGHT_INIT);
      end
    end else if (wr_en && (int'(wr_addr) < N_SYN)) begin
      weight[wr_addr] <= wr_data;
    end else begin
      for (int i = 0; i < N_SYN; i++) begin
        weight[i] <= weight[i];
      end
    end
  end

endmodule
